// File: rtl/bus_cycle_unit.sv
// bus_cycle_unit: bus interface unit between the CPU core and a multiplexed 8-bit AD bus.
// A core request of 1..WORD_BYTES bytes becomes sequential T1-T2-T3-(TW)-T4 byte cycles.
// Wait states are inserted from 'ready'. A non-zero MAX_WAIT aborts a stalled byte cycle
// with err.
// Optional feature macro: BUS_HOLD_EN enables HOLD/HLDA bus arbitration; when undefined,
// hold is ignored and hlda is tied low.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req/we/m_io/len/addr/wdata   core request (sampled in IDLE only)
//   rdata/busy/done/err          core response
//   a, ad_i, ad_o, ad_oe         address and multiplexed AD bus
//   ale iom dtr den_n rd_n wr_n  bus control strobes (8088 sense)
//   ready                        slave ready, sampled in T3/TW
//   hold, hlda                   bus request/grant

module bus_cycle_unit #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned MAX_WAIT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          we,
  input  logic                          m_io,
  input  logic [$clog2(WORD_BYTES):0]   len,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [8*WORD_BYTES-1:0]       wdata,
  output logic [8*WORD_BYTES-1:0]       rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [ADDR_W-1:0]             a,
  input  logic [7:0]                    ad_i,
  output logic [7:0]                    ad_o,
  output logic                          ad_oe,
  output logic                          ale,
  output logic                          iom,
  output logic                          dtr,
  output logic                          den_n,
  output logic                          rd_n,
  output logic                          wr_n,
  input  logic                          ready,
  input  logic                          hold,
  output logic                          hlda
);

  localparam int unsigned LenW  = $clog2(WORD_BYTES) + 1;
  localparam int unsigned DataW = 8 * WORD_BYTES;
  localparam int unsigned WaitW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StTw, StT4, StHold} state_e;

  state_e              state_q, state_d;
  logic [LenW-1:0]     k_q, k_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic                we_q, we_d;
  logic                m_io_q, m_io_d;
  logic [DataW-1:0]    wdata_q, wdata_d;
  logic [DataW-1:0]    rdata_q, rdata_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                abort_q, abort_d;
  logic                pending_q, pending_d;

  logic [7:0]          wbyte;
  logic                last;
  logic                timeout;
  logic                hold_req;
  logic [LenW-1:0]     len_eff;

`ifdef BUS_HOLD_EN
  assign hold_req = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign hold_req    = 1'b0;
`endif

  // Zero-length requests move one byte; oversize requests are clipped to a full word.
  always_comb begin
    len_eff = len;
    if (len == '0) begin
      len_eff = LenW'(1);
    end else if (len > LenW'(WORD_BYTES)) begin
      len_eff = LenW'(WORD_BYTES);
    end
  end

  always_comb begin
    wbyte = 8'h00;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (k_q == LenW'(i)) wbyte = wdata_q[8*i +: 8];
    end
  end

  assign last    = ((k_q + LenW'(1)) == len_q);
  // Fires on the MAX_WAIT-th consecutive TW; wait_q counts TW cycles already completed.
  assign timeout = (MAX_WAIT != 0) && ((32'(wait_q) + 32'd1) == MAX_WAIT);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    len_d     = len_q;
    a_d       = a_q;
    we_d      = we_q;
    m_io_d    = m_io_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wait_d    = wait_q;
    abort_d   = abort_q;
    pending_d = pending_q;

    ale   = 1'b0;
    rd_n  = 1'b1;
    wr_n  = 1'b1;
    den_n = 1'b1;
    dtr   = 1'b1;
    iom   = 1'b0;
    ad_oe = 1'b0;
    ad_o  = 8'h00;
    done  = 1'b0;
    err   = 1'b0;
    hlda  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (hold_req) begin
          pending_d = 1'b0;
          state_d   = StHold;
        end else if (req) begin
          we_d      = we;
          m_io_d    = m_io;
          len_d     = len_eff;
          a_d       = addr;
          wdata_d   = wdata;
          rdata_d   = '0;
          k_d       = '0;
          abort_d   = 1'b0;
          state_d   = StT1;
        end
      end
      StT1: begin
        ale     = 1'b1;
        ad_o    = a_q[7:0];
        ad_oe   = 1'b1;
        iom     = ~m_io_q;
        dtr     = we_q;
        state_d = StT2;
      end
      StT2: begin
        iom   = ~m_io_q;
        dtr   = we_q;
        den_n = 1'b0;
        rd_n  = we_q;
        wr_n  = ~we_q;
        if (we_q) begin
          ad_o  = wbyte;
          ad_oe = 1'b1;
        end
        wait_d  = '0;
        state_d = StT3;
      end
      StT3, StTw: begin
        iom   = ~m_io_q;
        dtr   = we_q;
        den_n = 1'b0;
        rd_n  = we_q;
        wr_n  = ~we_q;
        if (we_q) begin
          ad_o  = wbyte;
          ad_oe = 1'b1;
        end
        if (ready) begin
          if (!we_q) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
              if (k_q == LenW'(i)) rdata_d[8*i +: 8] = ad_i;
            end
          end
          state_d = StT4;
        end else if (state_q == StTw && timeout) begin
          abort_d = 1'b1;
          state_d = StT4;
        end else begin
          if (state_q == StTw) wait_d = wait_q + WaitW'(1);
          state_d = StTw;
        end
      end
      StT4: begin
        iom   = ~m_io_q;
        dtr   = we_q;
        den_n = 1'b0;
        if (we_q) begin
          ad_o  = wbyte;
          ad_oe = 1'b1;
        end
        if (last || abort_q) begin
          done      = 1'b1;
          err       = abort_q;
          pending_d = 1'b0;
          state_d   = hold_req ? StHold : StIdle;
        end else begin
          k_d       = k_q + LenW'(1);
          a_d       = a_q + ADDR_W'(1);
          pending_d = hold_req;
          state_d   = hold_req ? StHold : StT1;
        end
      end
      StHold: begin
`ifdef BUS_HOLD_EN
        hlda = 1'b1;
        if (!hold) begin
          state_d = pending_q ? StT1 : StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // A transfer parked in HOLD is still outstanding; a bare IDLE-side HOLD is not.
  assign busy  = (state_q != StIdle) && !(state_q == StHold && !pending_q);
  assign a     = a_q;
  assign rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= '0;
      len_q     <= '0;
      a_q       <= '0;
      we_q      <= 1'b0;
      m_io_q    <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wait_q    <= '0;
      abort_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      a_q       <= a_d;
      we_q      <= we_d;
      m_io_q    <= m_io_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wait_q    <= wait_d;
      abort_q   <= abort_d;
      pending_q <= pending_d;
    end
  end

endmodule
